memwb_pipe_stage: RTL

MEMWB_PIPE_STAGE -- requirements
Module: memwb_pipe_stage

---
 rtl/memwb_pkg.sv | 28 ++
 rtl/wb_src_mux.sv | 32 +++
 rtl/memwb_pipe_stage.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/memwb_pkg.sv
// memwb_pkg: shared types for the MEM/WB pipeline stage.
// Holds the write-back command record (default widths), the occupancy
// states of the buffered build, and a helper that sizes the source select.
package memwb_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

  // Write-back command as seen at the stage outputs (default widths).
  typedef struct packed {
    logic                      regwrite;
    logic [DEFAULT_ADDR_W-1:0] rd;
    logic [DEFAULT_DATA_W-1:0] wdata;
  } wb_cmd_t;

  // Number of entries held by the buffered (skid) build.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_t;

  // Width of the source select; at least one bit even for a single source.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_src_mux.sv
// wb_src_mux: NSRC-way write-back source selector.
// A select value with no matching source falls back to source 0.
module wb_src_mux #(
  parameter int NSRC   = 2,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 1
) (
  input  logic [SEL_W-1:0]       sel,
  input  logic [NSRC*DATA_W-1:0] src_data,
  output logic [DATA_W-1:0]      data
);

  logic [DATA_W-1:0] src_arr [NSRC];

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      assign src_arr[gi] = src_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Pick the matching source; source 0 is the default for out-of-range selects.
  always_comb begin
    data = src_arr[0];
    for (int k = 1; k < NSRC; k++) begin
      if (sel == SEL_W'(k)) begin
        data = src_arr[k];
      end
    end
  end

endmodule

// File: rtl/memwb_pipe_stage.sv
// memwb_pipe_stage: MEM->WB pipeline register with valid/ready handshake.
// Source selection and the x0 write guard happen at capture time.
// Build option MEMWB_SKID_EN: main + skid register with registered ready_o;
// without it, a single register whose ready_o depends on ready_i.
module memwb_pipe_stage
  import memwb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NSRC   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic                      regwrite_i,
  input  logic [sel_w(NSRC)-1:0]    wb_sel_i,
  input  logic [NSRC*DATA_W-1:0]    src_data_i,
  input  logic [ADDR_W-1:0]         rd_i,
  input  logic                      flush_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      regwrite_o,
  output logic [DATA_W-1:0]         wdata_o,
  output logic [ADDR_W-1:0]         rd_o
);

  localparam int SEL_W = sel_w(NSRC);

  logic [DATA_W-1:0] cap_wdata;
  logic              cap_regwrite;
  logic              in_fire;
  logic              out_fire;

  logic              main_valid_reg, main_valid_next;
  logic              main_regwrite_reg, main_regwrite_next;
  logic [ADDR_W-1:0] main_rd_reg, main_rd_next;
  logic [DATA_W-1:0] main_wdata_reg, main_wdata_next;

  wb_src_mux #(
    .NSRC   (NSRC),
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_src_mux (
    .sel      (wb_sel_i),
    .src_data (src_data_i),
    .data     (cap_wdata)
  );

  // Register 0 is hardwired, so a write to it is turned into a no-op here.
  assign cap_regwrite = regwrite_i && (rd_i != '0);

  assign in_fire  = valid_i && ready_o;
  assign out_fire = main_valid_reg && ready_i;

  assign valid_o    = main_valid_reg;
  assign regwrite_o = main_regwrite_reg;
  assign wdata_o    = main_wdata_reg;
  assign rd_o       = main_rd_reg;

`ifdef MEMWB_SKID_EN

  occ_state_t        occ_reg, occ_next;
  logic              ready_reg, ready_next;
  logic              skid_regwrite_reg, skid_regwrite_next;
  logic [ADDR_W-1:0] skid_rd_reg, skid_rd_next;
  logic [DATA_W-1:0] skid_wdata_reg, skid_wdata_next;

  // ready_o comes from a register; rst_n only masks it during reset.
  assign ready_o = rst_n && ready_reg;

  // Occupancy FSM: routes captures to main or skid and drains skid into main.
  always_comb begin
    occ_next           = occ_reg;
    main_regwrite_next = main_regwrite_reg;
    main_rd_next       = main_rd_reg;
    main_wdata_next    = main_wdata_reg;
    skid_regwrite_next = skid_regwrite_reg;
    skid_rd_next       = skid_rd_reg;
    skid_wdata_next    = skid_wdata_reg;
    case (occ_reg)
      OCC_EMPTY: begin
        if (in_fire) begin
          occ_next           = OCC_ONE;
          main_regwrite_next = cap_regwrite;
          main_rd_next       = rd_i;
          main_wdata_next    = cap_wdata;
        end
      end
      OCC_ONE: begin
        if (in_fire && out_fire) begin
          main_regwrite_next = cap_regwrite;
          main_rd_next       = rd_i;
          main_wdata_next    = cap_wdata;
        end else if (in_fire) begin
          occ_next           = OCC_TWO;
          skid_regwrite_next = cap_regwrite;
          skid_rd_next       = rd_i;
          skid_wdata_next    = cap_wdata;
        end else if (out_fire) begin
          occ_next           = OCC_EMPTY;
          main_regwrite_next = 1'b0;
        end
      end
      OCC_TWO: begin
        if (out_fire) begin
          occ_next           = OCC_ONE;
          main_regwrite_next = skid_regwrite_reg;
          main_rd_next       = skid_rd_reg;
          main_wdata_next    = skid_wdata_reg;
        end
      end
      default: begin
        occ_next           = OCC_EMPTY;
        main_regwrite_next = 1'b0;
      end
    endcase
    if (flush_i) begin
      occ_next           = OCC_EMPTY;
      main_regwrite_next = 1'b0;
    end
    main_valid_next = (occ_next != OCC_EMPTY);
    ready_next      = (occ_next != OCC_TWO);
  end

  // Skid-side state: occupancy, registered ready and the skid entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_reg           <= OCC_EMPTY;
      ready_reg         <= 1'b1;
      skid_regwrite_reg <= 1'b0;
      skid_rd_reg       <= '0;
      skid_wdata_reg    <= '0;
    end else begin
      occ_reg           <= occ_next;
      ready_reg         <= ready_next;
      skid_regwrite_reg <= skid_regwrite_next;
      skid_rd_reg       <= skid_rd_next;
      skid_wdata_reg    <= skid_wdata_next;
    end
  end

`else

  // Accept when empty or when the held entry leaves this same cycle.
  assign ready_o = rst_n && (!main_valid_reg || ready_i);

  // Single-entry update: capture wins over drain, flush wins over both.
  always_comb begin
    main_valid_next    = main_valid_reg;
    main_regwrite_next = main_regwrite_reg;
    main_rd_next       = main_rd_reg;
    main_wdata_next    = main_wdata_reg;
    if (in_fire) begin
      main_valid_next    = 1'b1;
      main_regwrite_next = cap_regwrite;
      main_rd_next       = rd_i;
      main_wdata_next    = cap_wdata;
    end else if (out_fire) begin
      main_valid_next    = 1'b0;
      main_regwrite_next = 1'b0;
    end
    if (flush_i) begin
      main_valid_next    = 1'b0;
      main_regwrite_next = 1'b0;
    end
  end

`endif

  // Main (output) register, shared by both builds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_reg    <= 1'b0;
      main_regwrite_reg <= 1'b0;
      main_rd_reg       <= '0;
      main_wdata_reg    <= '0;
    end else begin
      main_valid_reg    <= main_valid_next;
      main_regwrite_reg <= main_regwrite_next;
      main_rd_reg       <= main_rd_next;
      main_wdata_reg    <= main_wdata_next;
    end
  end

endmodule
